// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared definitions for the ID/EX register and hazard controller.
package id_ex_hazard_ctrl_pkg;

    // Bit positions in the execute control bus
    localparam int ALU_OP_LSB = 0;
    localparam int ALU_OP_MSB = 3;
    localparam int ALU_SRC    = 4;
    localparam int REG_DST    = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    typedef struct packed {
        logic mem_read;
        logic reg_write;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_ctrl_hazard_detect.sv
// Purpose: combinational load-use and taken-branch detection for the EX slot.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller masks the terms with the memory stall.
module id_ex_hazard_ctrl_hazard_detect #(
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     ex_valid,
    input  logic                     ex_mem_read,
    input  logic                     ex_branch,
    input  logic [REG_ADDR_BITS-1:0] ex_rt_addr,
    input  logic                     ex_zero_flag,
    input  logic                     id_valid,
    input  logic [REG_ADDR_BITS-1:0] id_rs_addr,
    input  logic [REG_ADDR_BITS-1:0] id_rt_addr,
    input  logic                     id_alu_src,
    output logic                     taken,
    output logic                     lu
);

    logic rs_match;
    logic rt_match;

    assign taken = ex_valid & ex_branch & ex_zero_flag;

    // rt is only a source when the ALU takes it instead of the immediate;
    // register 0 is hardwired and can never carry a hazard.
    assign rs_match = (ex_rt_addr == id_rs_addr);
    assign rt_match = (ex_rt_addr == id_rt_addr) & ~id_alu_src;
    assign lu       = ex_valid & ex_mem_read & id_valid & (ex_rt_addr != '0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Purpose: ID/EX pipeline register with load-use bubble, branch flush and memory-stall freeze.
// Latency: 1 cycle from decode fields to ex_* outputs.
// Backpressure: mem_busy_in freezes every register and deasserts the PC and IF/ID enables.
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int EXEC_BUS_WIDTH = 6,
    parameter int REG_ADDR_BITS  = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid_in,
    input  logic [EXEC_BUS_WIDTH-1:0] id_exec_bus_in,
    input  logic                      id_mem_read_in,
    input  logic                      id_reg_write_in,
    input  logic                      id_branch_in,
    input  logic [REG_ADDR_BITS-1:0]  id_rs_addr_in,
    input  logic [REG_ADDR_BITS-1:0]  id_rt_addr_in,
    input  logic [DATA_WIDTH-1:0]     id_rs_data_in,
    input  logic [DATA_WIDTH-1:0]     id_rt_data_in,
    input  logic [DATA_WIDTH-1:0]     id_imm_in,
    input  logic                      ex_zero_flag_in,
    input  logic                      mem_busy_in,
    input  logic                      perf_clear_in,
    output logic                      ex_valid_out,
    output logic [EXEC_BUS_WIDTH-1:0] ex_exec_bus_out,
    output logic                      ex_mem_read_out,
    output logic                      ex_reg_write_out,
    output logic                      ex_branch_out,
    output logic [REG_ADDR_BITS-1:0]  ex_rs_addr_out,
    output logic [REG_ADDR_BITS-1:0]  ex_rt_addr_out,
    output logic [DATA_WIDTH-1:0]     ex_rs_data_out,
    output logic [DATA_WIDTH-1:0]     ex_rt_data_out,
    output logic [DATA_WIDTH-1:0]     ex_imm_out,
    output logic                      pc_write_out,
    output logic                      if_id_write_out,
    output logic                      if_id_flush_out,
    output logic [1:0]                state_out,
    output logic [CNT_WIDTH-1:0]      stall_count_out
);

    typedef struct packed {
        logic                      valid;
        logic [EXEC_BUS_WIDTH-1:0] exec_bus;
        ctrl_t                     ctrl;
        logic [REG_ADDR_BITS-1:0]  rs_addr;
        logic [REG_ADDR_BITS-1:0]  rt_addr;
        logic [DATA_WIDTH-1:0]     rs_data;
        logic [DATA_WIDTH-1:0]     rt_data;
        logic [DATA_WIDTH-1:0]     imm;
    } ex_reg_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    ex_reg_t             ex_q, ex_d;
    state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                taken, lu;

    id_ex_hazard_ctrl_hazard_detect #(
        .REG_ADDR_BITS (REG_ADDR_BITS)
    ) u_hazard_detect (
        .ex_valid     (ex_q.valid),
        .ex_mem_read  (ex_q.ctrl.mem_read),
        .ex_branch    (ex_q.ctrl.branch),
        .ex_rt_addr   (ex_q.rt_addr),
        .ex_zero_flag (ex_zero_flag_in),
        .id_valid     (id_valid_in),
        .id_rs_addr   (id_rs_addr_in),
        .id_rt_addr   (id_rt_addr_in),
        .id_alu_src   (id_exec_bus_in[ALU_SRC]),
        .taken        (taken),
        .lu           (lu)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!mem_busy_in) begin
            if (taken)   state_d = ST_FLUSH;
            else if (lu) state_d = ST_BUBBLE;
            else         state_d = ST_RUN;
        end
    end

    // A taken branch outranks load-use: the ID instruction is on the wrong path.
    always_comb begin
        pc_write_out    = 1'b1;
        if_id_write_out = 1'b1;
        if_id_flush_out = 1'b0;
        if (mem_busy_in) begin
            pc_write_out    = 1'b0;
            if_id_write_out = 1'b0;
        end else if (taken) begin
            if_id_flush_out = 1'b1;
        end else if (lu) begin
            pc_write_out    = 1'b0;
            if_id_write_out = 1'b0;
        end
    end

    always_comb begin
        ex_d = '0;
        if (!taken && !lu && id_valid_in) begin
            ex_d.valid          = 1'b1;
            ex_d.exec_bus       = id_exec_bus_in;
            ex_d.ctrl.mem_read  = id_mem_read_in;
            ex_d.ctrl.reg_write = id_reg_write_in;
            ex_d.ctrl.branch    = id_branch_in;
            ex_d.rs_addr        = id_rs_addr_in;
            ex_d.rt_addr        = id_rt_addr_in;
            ex_d.rs_data        = id_rs_data_in;
            ex_d.rt_data        = id_rt_data_in;
            ex_d.imm            = id_imm_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)             ex_q <= '0;
        else if (!mem_busy_in) ex_q <= ex_d;
    end

    always_ff @(posedge clk) begin
        if (reset || perf_clear_in)
            cnt_q <= '0;
        else if (!pc_write_out && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

    assign ex_valid_out     = ex_q.valid;
    assign ex_exec_bus_out  = ex_q.exec_bus;
    assign ex_mem_read_out  = ex_q.ctrl.mem_read;
    assign ex_reg_write_out = ex_q.ctrl.reg_write;
    assign ex_branch_out    = ex_q.ctrl.branch;
    assign ex_rs_addr_out   = ex_q.rs_addr;
    assign ex_rt_addr_out   = ex_q.rt_addr;
    assign ex_rs_data_out   = ex_q.rs_data;
    assign ex_rt_data_out   = ex_q.rt_data;
    assign ex_imm_out       = ex_q.imm;
    assign state_out        = state_q;
    assign stall_count_out  = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: directed vector table, hand sequences, randomized run against a reference model.
module tb_id_ex_hazard_ctrl;

    localparam int CW      = 8;
    localparam int CNT_TOP = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset, id_valid_in, id_mem_read_in, id_reg_write_in, id_branch_in;
    logic [5:0]  id_exec_bus_in;
    logic [4:0]  id_rs_addr_in, id_rt_addr_in;
    logic [31:0] id_rs_data_in, id_rt_data_in, id_imm_in;
    logic        ex_zero_flag_in, mem_busy_in, perf_clear_in;
    logic        ex_valid_out, ex_mem_read_out, ex_reg_write_out, ex_branch_out;
    logic [5:0]  ex_exec_bus_out;
    logic [4:0]  ex_rs_addr_out, ex_rt_addr_out;
    logic [31:0] ex_rs_data_out, ex_rt_data_out, ex_imm_out;
    logic        pc_write_out, if_id_write_out, if_id_flush_out;
    logic [1:0]  state_out;
    logic [CW-1:0] stall_count_out;

    always #5 clk = ~clk;

    id_ex_hazard_ctrl #(.DATA_WIDTH(32), .EXEC_BUS_WIDTH(6), .REG_ADDR_BITS(5), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .id_valid_in(id_valid_in), .id_exec_bus_in(id_exec_bus_in),
        .id_mem_read_in(id_mem_read_in), .id_reg_write_in(id_reg_write_in), .id_branch_in(id_branch_in),
        .id_rs_addr_in(id_rs_addr_in), .id_rt_addr_in(id_rt_addr_in), .id_rs_data_in(id_rs_data_in),
        .id_rt_data_in(id_rt_data_in), .id_imm_in(id_imm_in), .ex_zero_flag_in(ex_zero_flag_in),
        .mem_busy_in(mem_busy_in), .perf_clear_in(perf_clear_in), .ex_valid_out(ex_valid_out),
        .ex_exec_bus_out(ex_exec_bus_out), .ex_mem_read_out(ex_mem_read_out),
        .ex_reg_write_out(ex_reg_write_out), .ex_branch_out(ex_branch_out),
        .ex_rs_addr_out(ex_rs_addr_out), .ex_rt_addr_out(ex_rt_addr_out),
        .ex_rs_data_out(ex_rs_data_out), .ex_rt_data_out(ex_rt_data_out), .ex_imm_out(ex_imm_out),
        .pc_write_out(pc_write_out), .if_id_write_out(if_id_write_out),
        .if_id_flush_out(if_id_flush_out), .state_out(state_out), .stall_count_out(stall_count_out)
    );

    typedef struct packed {
        bit rst, vld; bit [5:0] bus; bit mr, rw, br; bit [4:0] rs, rt;
        bit [31:0] rsd, rtd, imm; bit zf, busy, clr;
    } in_t;

    typedef struct packed {
        bit v; bit [5:0] bus; bit mr, rw, br; bit [4:0] rs, rt; bit [31:0] rsd, rtd, imm;
    } ex_t;

    typedef struct {
        in_t i; bit pcw, ifw, fl, exv; bit [31:0] rsd, rtd; bit [1:0] st; int cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic in_t mk(bit vld, bit [5:0] bus, bit mr, bit br, bit [4:0] rs, bit [4:0] rt,
                               bit [31:0] rsd, bit [31:0] rtd, bit zf, bit busy);
        in_t r;
        r = '0;
        r.vld = vld; r.bus = bus; r.mr = mr; r.rw = mr; r.br = br; r.rs = rs; r.rt = rt;
        r.rsd = rsd; r.rtd = rtd; r.imm = rsd + 32'h100; r.zf = zf; r.busy = busy;
        return r;
    endfunction

    task automatic add(in_t i, bit pcw, bit ifw, bit fl, bit exv, bit [31:0] rsd, bit [31:0] rtd,
                       bit [1:0] st, int cnt);
        vec_t v;
        v.i = i; v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.exv = exv;
        v.rsd = rsd; v.rtd = rtd; v.st = st; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(in_t i);
        reset = i.rst; id_valid_in = i.vld; id_exec_bus_in = i.bus; id_mem_read_in = i.mr;
        id_reg_write_in = i.rw; id_branch_in = i.br; id_rs_addr_in = i.rs; id_rt_addr_in = i.rt;
        id_rs_data_in = i.rsd; id_rt_data_in = i.rtd; id_imm_in = i.imm;
        ex_zero_flag_in = i.zf; mem_busy_in = i.busy; perf_clear_in = i.clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_t dut_ex();
        ex_t e;
        e.v = ex_valid_out; e.bus = ex_exec_bus_out; e.mr = ex_mem_read_out; e.rw = ex_reg_write_out;
        e.br = ex_branch_out; e.rs = ex_rs_addr_out; e.rt = ex_rt_addr_out;
        e.rsd = ex_rs_data_out; e.rtd = ex_rt_data_out; e.imm = ex_imm_out;
        return e;
    endfunction

    task automatic chk_comb(string tag, bit pcw, bit ifw, bit fl);
        chk({tag, " pc_write"}, pc_write_out, pcw);
        chk({tag, " if_id_write"}, if_id_write_out, ifw);
        chk({tag, " if_id_flush"}, if_id_flush_out, fl);
    endtask

    in_t  ri, h;
    ex_t  m;
    int   st, cnt;
    bit   taken, lu, epcw;

    initial begin
        // Directed flow; each row's EX expectations come from the previous rows.
        add(mk(1, 6'h00, 0, 0, 3, 4, 32'h11, 32'h22, 0, 0), 1, 1, 0, 1, 32'h11, 32'h22, 0, 0);
        add(mk(1, 6'h00, 1, 0, 1, 5, 32'h33, 32'h34, 0, 0), 1, 1, 0, 1, 32'h33, 32'h34, 0, 0);
        add(mk(1, 6'h00, 0, 0, 5, 7, 32'h44, 32'h45, 0, 0), 0, 0, 0, 0, 0, 0, 1, 1);
        add(mk(1, 6'h00, 0, 0, 5, 7, 32'h44, 32'h45, 0, 0), 1, 1, 0, 1, 32'h44, 32'h45, 0, 1);
        add(mk(1, 6'h00, 1, 0, 2, 0, 32'h55, 32'h56, 0, 0), 1, 1, 0, 1, 32'h55, 32'h56, 0, 1);
        add(mk(1, 6'h00, 0, 0, 0, 0, 32'h66, 32'h67, 0, 0), 1, 1, 0, 1, 32'h66, 32'h67, 0, 1);
        add(mk(1, 6'h00, 1, 0, 1, 6, 32'h77, 32'h78, 0, 0), 1, 1, 0, 1, 32'h77, 32'h78, 0, 1);
        add(mk(1, 6'h10, 0, 0, 2, 6, 32'h88, 32'h89, 0, 0), 1, 1, 0, 1, 32'h88, 32'h89, 0, 1);
        add(mk(1, 6'h00, 1, 1, 1, 9, 32'h99, 32'h9A, 0, 0), 1, 1, 0, 1, 32'h99, 32'h9A, 0, 1);
        add(mk(1, 6'h00, 0, 0, 9, 2, 32'hAA, 32'hAB, 1, 0), 1, 1, 1, 0, 0, 0, 2, 1);
        add(mk(1, 6'h00, 0, 0, 3, 2, 32'hBB, 32'hBC, 0, 0), 1, 1, 0, 1, 32'hBB, 32'hBC, 0, 1);
        add(mk(0, 6'h00, 0, 0, 3, 2, 32'hCC, 32'hCD, 0, 0), 1, 1, 0, 0, 0, 0, 0, 1);

        h = '0; h.rst = 1'b1;
        drive(h);
        tick(); tick();
        chk("reset ex", dut_ex(), '0);
        chk("reset state", state_out, 2'd0);
        chk("reset count", stall_count_out, 0);

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            #1;
            chk_comb($sformatf("v%0d", k), tbl[k].pcw, tbl[k].ifw, tbl[k].fl);
            tick();
            chk($sformatf("v%0d ex_valid", k), ex_valid_out, tbl[k].exv);
            chk($sformatf("v%0d ex_rs_data", k), ex_rs_data_out, tbl[k].rsd);
            chk($sformatf("v%0d ex_rt_data", k), ex_rt_data_out, tbl[k].rtd);
            chk($sformatf("v%0d state", k), state_out, tbl[k].st);
            chk($sformatf("v%0d count", k), stall_count_out, tbl[k].cnt);
            if (!tbl[k].exv) chk($sformatf("v%0d bubble", k), dut_ex(), '0);
        end

        // Taken branch held in EX across a 3-cycle memory stall.
        drive(mk(1, 6'h00, 0, 1, 1, 2, 32'h12, 32'h21, 0, 0));
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(mk(1, 6'h00, 0, 0, 1, 2, 32'h34, 32'h43, 1, 1));
            #1;
            chk_comb($sformatf("busy%0d", c), 0, 0, 0);
            tick();
            chk($sformatf("busy%0d ex_rs_data", c), ex_rs_data_out, 32'h12);
            chk($sformatf("busy%0d ex_branch", c), ex_branch_out, 1'b1);
            chk($sformatf("busy%0d state", c), state_out, 2'd0);
            chk($sformatf("busy%0d count", c), stall_count_out, 2 + c);
        end
        drive(mk(1, 6'h00, 0, 0, 1, 2, 32'h34, 32'h43, 1, 0));
        #1;
        chk_comb("busy_drop", 1, 1, 1);
        tick();
        chk("busy_drop ex", dut_ex(), '0);
        chk("busy_drop state", state_out, 2'd2);
        chk("busy_drop count", stall_count_out, 4);

        // Reset in the middle of a load-use bubble.
        drive(mk(1, 6'h00, 1, 0, 1, 5, 32'h5, 32'h6, 0, 0));
        tick();
        drive(mk(1, 6'h00, 0, 0, 5, 1, 32'h7, 32'h8, 0, 0));
        tick();
        chk("lu state", state_out, 2'd1);
        h = mk(1, 6'h00, 0, 0, 5, 1, 32'h7, 32'h8, 0, 0);
        h.rst = 1'b1;
        drive(h);
        tick();
        chk("rst_bubble ex", dut_ex(), '0);
        chk("rst_bubble state", state_out, 2'd0);
        chk("rst_bubble count", stall_count_out, 0);

        // Saturation, then clear winning over a simultaneous stall.
        drive(mk(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int c = 0; c < CNT_TOP + 5; c++) tick();
        chk("saturate", stall_count_out, CNT_TOP);
        h = mk(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 1);
        h.clr = 1'b1;
        drive(h);
        tick();
        chk("clear_in_stall", stall_count_out, 0);
        drive(mk(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        chk("count_after_clear", stall_count_out, 1);

        // Randomized traffic against the reference model.
        m = '0; st = 0; cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            ri      = '0;
            ri.rst  = (n == 0) || ($urandom_range(99) == 0);
            ri.vld  = ($urandom_range(3) != 0);
            ri.bus  = 6'($urandom);
            ri.mr   = ($urandom_range(2) == 0);
            ri.rw   = 1'($urandom);
            ri.br   = ($urandom_range(3) == 0);
            ri.rs   = 5'($urandom_range(3));
            ri.rt   = 5'($urandom_range(3));
            ri.rsd  = $urandom;
            ri.rtd  = $urandom;
            ri.imm  = $urandom;
            ri.zf   = 1'($urandom);
            ri.busy = ($urandom_range(4) == 0);
            ri.clr  = ($urandom_range(49) == 0);
            drive(ri);
            #1;
            taken = m.v && m.br && ri.zf;
            lu    = m.v && m.mr && ri.vld && (m.rt != 0) &&
                    ((m.rt == ri.rs) || ((m.rt == ri.rt) && !ri.bus[4]));
            epcw  = !ri.busy && (taken || !lu);
            chk_comb($sformatf("rand%0d", n), epcw, epcw, !ri.busy && taken);
            if (ri.rst) begin
                m = '0; st = 0; cnt = 0;
            end else begin
                if (!ri.busy) begin
                    if (taken)   begin m = '0; st = 2; end
                    else if (lu) begin m = '0; st = 1; end
                    else begin
                        st = 0;
                        m  = '0;
                        if (ri.vld) begin
                            m.v = 1'b1; m.bus = ri.bus; m.mr = ri.mr; m.rw = ri.rw; m.br = ri.br;
                            m.rs = ri.rs; m.rt = ri.rt; m.rsd = ri.rsd; m.rtd = ri.rtd; m.imm = ri.imm;
                        end
                    end
                end
                if (ri.clr) cnt = 0;
                else if (!epcw && cnt < CNT_TOP) cnt = cnt + 1;
            end
            tick();
            chk($sformatf("rand%0d ex", n), dut_ex(), m);
            chk($sformatf("rand%0d state", n), state_out, st);
            chk($sformatf("rand%0d count", n), stall_count_out, cnt);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- ID/EX pipeline register plus hazard controller that sequences the execute stage.
- Captures decoded operands and the execute control bus from decode, and presents them to the execute stage one cycle later.
- Detects load-use hazards and inserts a one-cycle bubble; flushes wrong-path instructions on a taken branch; freezes the front pipeline on a memory stall.
- Drives the PC and IF/ID write-enables and the IF/ID flush, and keeps a stall-cycle performance counter.

Parameters:
DATA_WIDTH, 32, operand/immediate width
EXEC_BUS_WIDTH, 6, execute control bus width ([3:0] ALU opcode, [4] alu_src, [5] reg_dst)
REG_ADDR_BITS, 5, register address width
CNT_WIDTH, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_valid_in  in  1  decode slot holds a real instruction
id_exec_bus_in  in  EXEC_BUS_WIDTH  execute control bus from decode
id_mem_read_in  in  1  instruction is a load
id_reg_write_in  in  1  instruction writes the register file
id_branch_in  in  1  instruction is a conditional branch
id_rs_addr_in  in  REG_ADDR_BITS  rs address
id_rt_addr_in  in  REG_ADDR_BITS  rt address
id_rs_data_in  in  DATA_WIDTH  rs value
id_rt_data_in  in  DATA_WIDTH  rt value
id_imm_in  in  DATA_WIDTH  sign-extended immediate
ex_zero_flag_in  in  1  ALU zero flag from execute stage
mem_busy_in  in  1  data memory not ready
perf_clear_in  in  1  clear stall counter
ex_valid_out  out  1  EX slot valid
ex_exec_bus_out  out  EXEC_BUS_WIDTH  registered control bus
ex_mem_read_out, ex_reg_write_out, ex_branch_out  out  1 each  registered controls
ex_rs_addr_out, ex_rt_addr_out  out  REG_ADDR_BITS  registered addresses
ex_rs_data_out, ex_rt_data_out, ex_imm_out  out  DATA_WIDTH  registered operands
pc_write_out  out  1  PC update enable (combinational)
if_id_write_out  out  1  IF/ID register enable (combinational)
if_id_flush_out  out  1  IF/ID clear (combinational)
state_out  out  2  FSM state: RUN=0, BUBBLE=1, FLUSH=2
stall_count_out  out  CNT_WIDTH  saturating stall-cycle count

Behaviour:
- Reset (synchronous, dominates everything, including mid-stall or mid-flush):
  - all ex_* outputs 0; state RUN; stall_count_out 0.
- Hazard terms, evaluated combinationally each cycle:
  - taken = ex_valid & ex_branch & ex_zero_flag_in
  - lu = ex_valid & ex_mem_read & id_valid & ex_rt_addr != 0 & (ex_rt_addr == id_rs_addr | (ex_rt_addr == id_rt_addr & id_exec_bus[4] == 0))
- Priority, highest first:
  - mem_busy_in: hold every register; pc_write = if_id_write = 0; if_id_flush = 0; state holds. A pending taken branch stays in EX and flushes when busy drops.
  - taken: next EX = bubble (valid and all controls 0, data 0); if_id_flush = 1; pc_write = 1 (PC loads the branch target); if_id_write = 1; next state FLUSH. A simultaneous lu is ignored because the ID instruction is on the wrong path.
  - lu: next EX = bubble; pc_write = if_id_write = 0 (hold IF and ID); next state BUBBLE.
  - otherwise: EX <= ID fields (latency 1 cycle; invalid ID loads as a bubble); pc_write = if_id_write = 1; next state RUN.
- BUBBLE and FLUSH each last exactly one cycle, then return to RUN unless a new condition applies. lu cannot re-trigger in BUBBLE because EX then holds a bubble.
- Stall counter:
  - increments by 1 on each cycle where pc_write_out == 0 (busy or lu); saturates at all-ones.
  - perf_clear_in forces 0 and takes priority over increment; reset also clears it.

Decomposition:
- Shared package: exec bus bit indices (ALU_SRC=4, REG_DST=5, ALU_OP range [3:0]), FSM state encodings, bubble constant.
- One sub-module: hazard_detect (combinational lu/taken terms). The register, FSM and counter stay in the top.

Test Plan:
- Straight-line flow: id_valid, rs=3, rt=4, data 0x11/0x22, no hazards → next cycle ex_rs_data=0x11, ex_rt_data=0x22; pc_write=1; state RUN.
- Load-use: EX holds load with rt=5; ID has rs=5 → pc_write=0, if_id_write=0 for 1 cycle; EX bubble; state BUBBLE; next cycle ID enters EX; stall_count=1.
- No false hazard: load rt=0, ID rs=0 → no stall. Load rt=6, ID rt=6 with alu_src=1 → no stall.
- Taken branch: EX branch with zero_flag=1, same cycle as a load-use on ID → if_id_flush=1, pc_write=1, EX bubble, state FLUSH; stall_count unchanged.
- mem_busy for 3 cycles with a taken branch in EX → outputs frozen, flush=0, stall_count +3; flush fires on the cycle busy drops.
- Reset asserted during BUBBLE → next cycle all ex_* 0, state RUN, count 0. Counter at 0xFFFF plus a stall → stays 0xFFFF; perf_clear during a stall → 0.
